// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : icache_pkg
//  Purpose : Shared widths, FSM state type and address helper for the
//            direct-mapped instruction cache.
//  Rev     : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int c_addr_len        = 32;
  localparam int c_inst_len        = 32;
  localparam int c_index_bits_dflt = 7;

  typedef enum logic [0:0] {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_t;

  // Refills always fetch a whole word, so the byte offset is cleared.
  function automatic logic [c_addr_len-1:0] word_align(input logic [c_addr_len-1:0] a);
    return {a[c_addr_len-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module  : icache_if
//  Purpose : Bundles the IF-stage fetch handshake and the mem_ctrl refill
//            port. 'slave' is the cache's view, 'master' is the view of the
//            surrounding pipeline plus memory controller.
//  Rev     : 1.0  initial release
// ============================================================================
interface icache_if;
  import icache_pkg::*;

  // IF stage side
  logic                  is_jump;
  logic                  if_needed;
  logic [c_addr_len-1:0] if_addr;
  logic [c_inst_len-1:0] if_inst;
  logic                  if_rdy;

  // mem_ctrl side (the cache initiates refills)
  logic                  inst_needed;
  logic [c_inst_len-1:0] inst_addr;
  logic [c_inst_len-1:0] inst_data;
  logic                  inst_rdy;
  logic                  inst_busy;

  modport slave (
    input  is_jump, if_needed, if_addr, inst_data, inst_rdy, inst_busy,
    output if_inst, if_rdy, inst_needed, inst_addr
  );

  modport master (
    output is_jump, if_needed, if_addr, inst_data, inst_rdy, inst_busy,
    input  if_inst, if_rdy, inst_needed, inst_addr
  );

endinterface
`default_nettype wire

// File: rtl/icache_store.sv
`default_nettype none
// ============================================================================
//  Module  : icache_store
//  Purpose : Valid/tag/data line storage: one synchronous write port and one
//            combinational read port.
//  Rev     : 1.0  initial release
// ============================================================================
module icache_store #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 23,
  parameter int DATA_BITS  = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_we,
  input  wire logic [INDEX_BITS-1:0] i_widx,
  input  wire logic [TAG_BITS-1:0]   i_wtag,
  input  wire logic [DATA_BITS-1:0]  i_wdata,
  input  wire logic [INDEX_BITS-1:0] i_ridx,
  output logic                       o_valid,
  output logic [TAG_BITS-1:0]        o_tag,
  output logic [DATA_BITS-1:0]       o_data
);

  localparam int c_lines = 1 << INDEX_BITS;

  logic [c_lines-1:0]   r_valid;
  logic [TAG_BITS-1:0]  r_tag  [c_lines];
  logic [DATA_BITS-1:0] r_data [c_lines];

  // Valid bits: cleared by reset, set by a fill (overwrites any older line).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag/data payload needs no reset; it is meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module  : icache
//  Purpose : Direct-mapped, one-word-per-line instruction cache between IF and
//            mem_ctrl. Hits answer one cycle after acceptance; misses refill
//            through mem_ctrl. A jump during a refill lets the refill finish
//            but suppresses the response to IF.
//  Config  : define ICACHE_PERF_EN to add hit_cnt / miss_cnt counters.
//  Rev     : 1.0  initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = c_index_bits_dflt
) (
  input  wire logic  clk,
  input  wire logic  rst,
  icache_if.slave    bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int c_tag_bits = c_addr_len - INDEX_BITS - 2;

  ic_state_t             r_state, w_state_nxt;
  logic                  r_if_rdy, w_if_rdy_nxt;
  logic [c_inst_len-1:0] r_if_inst, w_if_inst_nxt;
  logic [c_inst_len-1:0] r_inst_addr, w_inst_addr_nxt;
  logic                  r_drop, w_drop_nxt;

  logic                  w_lookup, w_hit, w_miss, w_fill;
  logic                  w_rvalid;
  logic [c_tag_bits-1:0] w_rtag, w_atag, w_wtag;
  logic [c_inst_len-1:0] w_rdata;
  logic [INDEX_BITS-1:0] w_ridx, w_widx;

  assign w_ridx = bus.if_addr[INDEX_BITS+1:2];
  assign w_atag = bus.if_addr[c_addr_len-1:INDEX_BITS+2];
  assign w_widx = r_inst_addr[INDEX_BITS+1:2];
  assign w_wtag = r_inst_addr[c_addr_len-1:INDEX_BITS+2];

  // Lookups happen only in IDLE, so a fill never races a lookup.
  assign w_lookup = (r_state == IC_IDLE) && bus.if_needed && !bus.is_jump;
  assign w_hit    = w_lookup && w_rvalid && (w_rtag == w_atag);
  assign w_miss   = w_lookup && !w_hit;
  assign w_fill   = (r_state == IC_REFILL) && bus.inst_rdy;

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (c_tag_bits),
    .DATA_BITS  (c_inst_len)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_fill),
    .i_widx  (w_widx),
    .i_wtag  (w_wtag),
    .i_wdata (bus.inst_data),
    .i_ridx  (w_ridx),
    .o_valid (w_rvalid),
    .o_tag   (w_rtag),
    .o_data  (w_rdata)
  );

  // Next-state and response logic for the IDLE/REFILL controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_if_rdy_nxt    = 1'b0;
    w_if_inst_nxt   = r_if_inst;
    w_inst_addr_nxt = r_inst_addr;
    w_drop_nxt      = r_drop;
    case (r_state)
      IC_IDLE: begin
        if (w_hit) begin
          w_if_rdy_nxt  = 1'b1;
          w_if_inst_nxt = w_rdata;
        end else if (w_miss) begin
          w_inst_addr_nxt = word_align(bus.if_addr);
          w_drop_nxt      = 1'b0;
          w_state_nxt     = IC_REFILL;
        end
      end
      IC_REFILL: begin
        // A redirect abandons the answer, not the memory transaction.
        if (bus.is_jump) begin
          w_drop_nxt = 1'b1;
        end
        if (bus.inst_rdy) begin
          w_state_nxt = IC_IDLE;
          if (!r_drop && !bus.is_jump) begin
            w_if_rdy_nxt  = 1'b1;
            w_if_inst_nxt = bus.inst_data;
          end
        end
      end
      default: w_state_nxt = IC_IDLE;
    endcase
  end

  // State and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IC_IDLE;
      r_if_rdy    <= 1'b0;
      r_if_inst   <= '0;
      r_inst_addr <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_if_rdy    <= w_if_rdy_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  // Request drops in the rdy cycle so mem_ctrl never starts a second read.
  assign bus.inst_needed = (r_state == IC_REFILL) && !bus.inst_rdy;
  assign bus.inst_addr   = r_inst_addr;
  assign bus.if_rdy      = r_if_rdy;
  assign bus.if_inst     = r_if_inst;

`ifdef ICACHE_PERF_EN
  // Performance counters: accepted hits and started refills, free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (w_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (w_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
